// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: read-side handshake between an asynchronous FIFO and its
// serial transmit consumer. The FIFO is the master (presents empty flag and
// first-word-fall-through data); the transmitter is the slave (returns the
// read-increment strobe).
interface fifo_uart_tx_if #(
   parameter int unsigned D_SIZE = 8
);
   logic              i_empty;
   logic [D_SIZE-1:0] i_rd_data;
   logic              o_rd_inc;

   modport master (
      output i_empty,
      output i_rd_data,
      input  o_rd_inc
   );

   modport slave (
      input  i_empty,
      input  i_rd_data,
      output o_rd_inc
   );
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a first-word-fall-through FIFO and shifts each word out
// as a UART frame (start, data LSB-first, optional parity, stop).
// Build option FIFO_UART_TX_PARITY_EN: when defined, the parity state and the
// parity capture registers are built; when undefined every frame is
// start + D_SIZE data + stop and i_par_en/i_par_typ are ignored.
module fifo_uart_tx #(
   parameter int unsigned D_SIZE       = 8,
   parameter int unsigned CLKS_PER_BIT = 1
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   fifo_uart_tx_if.slave rd_if,
   input  logic          i_par_en,
   input  logic          i_par_typ,
   input  logic          i_hold,
   output logic          o_tx_out,
   output logic          o_busy
);

   localparam int unsigned   CW       = $clog2(CLKS_PER_BIT) + 1;
   localparam int unsigned   BW       = $clog2(D_SIZE + 1);
   localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(D_SIZE - 1);

`ifdef FIFO_UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t            state_q, state_d;
   logic [D_SIZE-1:0] shift_q, shift_d;
   logic [CW-1:0]     cyc_q,   cyc_d;
   logic [BW-1:0]     bit_q,   bit_d;
   logic              tx_q,    tx_d;
   logic              busy_q,  busy_d;
   logic              bit_done;
   logic              load;

`ifdef FIFO_UART_TX_PARITY_EN
   logic              par_en_q,  par_en_d;
   logic              par_bit_q, par_bit_d;
`else
   logic              unused_par_cfg;
   assign unused_par_cfg = i_par_en ^ i_par_typ;
`endif

   // Next-state, word/parity capture and registered line/busy values.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      bit_d    = bit_q;
      tx_d     = 1'b1;
      busy_d   = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
`endif
      bit_done = (cyc_q == CYC_LAST);
      cyc_d    = (state_q == S_IDLE || bit_done) ? '0 : cyc_q + CW'(1);
      // Reset gates the pop so no word is consumed while the block is held.
      load     = i_rstn && !rd_if.i_empty && !i_hold &&
                 (state_q == S_IDLE || (state_q == S_STOP && bit_done));

      case (state_q)
         S_IDLE: ;
         S_START: begin
            if (bit_done) begin
               state_d = S_DATA;
               bit_d   = '0;
            end
         end
         S_DATA: begin
            if (bit_done) begin
               if (bit_q == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                  state_d = par_en_q ? S_PARITY : S_STOP;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d   = bit_q + BW'(1);
                  shift_d = shift_q >> 1;
               end
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_done) state_d = S_STOP;
         end
`endif
         S_STOP: begin
            if (bit_done) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A load from IDLE or from the final stop cycle starts the next frame
      // directly, giving back-to-back frames with no idle gap.
      if (load) begin
         state_d = S_START;
         shift_d = rd_if.i_rd_data;
         bit_d   = '0;
`ifdef FIFO_UART_TX_PARITY_EN
         par_en_d  = i_par_en;
         par_bit_d = (^rd_if.i_rd_data) ^ i_par_typ;
`endif
      end

      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
         S_PARITY: tx_d = par_bit_d;
`endif
         default:  tx_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State, datapath and output registers; reset returns the line to idle.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         cyc_q   <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cyc_q   <= cyc_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
`ifdef FIFO_UART_TX_PARITY_EN
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
`endif
      end
   end

   assign rd_if.o_rd_inc = load;
   assign o_tx_out       = tx_q;
   assign o_busy         = busy_q;

endmodule
